infix_sequencer: RTL

//  Front-end controller for the postfix evaluator. Accepts an infix token stream
//  and reorders it into postfix using shunting-yard with an internal operator LIFO.

---
 rtl/infix_sequencer_pkg.sv | 39 +++
 rtl/infix_sequencer_if.sv | 34 +++
 rtl/infix_sequencer_op_lifo.sv | 59 +++++
 rtl/infix_sequencer.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/infix_sequencer_pkg.sv
// Shared definitions for the infix-to-postfix sequencer.
// Contents: token kind codes, ASCII operator characters, FSM state enum and
// the operator precedence helper used when popping the operator LIFO.
package infix_sequencer_pkg;

    localparam logic [2:0] TOK_NUM  = 3'd0;
    localparam logic [2:0] TOK_OP   = 3'd1;
    localparam logic [2:0] TOK_LPAR = 3'd2;
    localparam logic [2:0] TOK_RPAR = 3'd3;
    localparam logic [2:0] TOK_END  = 3'd4;

    localparam logic [7:0] CH_ADD  = 8'h2B;  // '+'
    localparam logic [7:0] CH_SUB  = 8'h2D;  // '-'
    localparam logic [7:0] CH_MUL  = 8'h2A;  // '*'
    localparam logic [7:0] CH_DIV  = 8'h2F;  // '/'
    localparam logic [7:0] CH_LPAR = 8'h28;  // '('

    typedef enum logic [2:0] {
        ST_ACCEPT,
        ST_EMIT_NUM,
        ST_POP_PREC,
        ST_PUSH_OP,
        ST_POP_PAREN,
        ST_FLUSH,
        ST_FINISH,
        ST_ERR
    } state_e;

    // Precedence of an operator character; 0 means "not an operator",
    // which also ranks a parenthesis below every real operator.
    function automatic logic [1:0] prec(input logic [7:0] ch);
        case (ch)
            CH_MUL, CH_DIV: prec = 2'd2;
            CH_ADD, CH_SUB: prec = 2'd1;
            default:        prec = 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/infix_sequencer_if.sv
// Bundle of the token input channel, the evaluator strobe interface and the
// sequencer status flags.
//   TOK_VALID/TOK_READY/TOK_KIND/TOK_DATA : infix token handshake
//   EV_NUMBER/EV_NUMBER_STB/EV_SIGN/EV_SIGN_STB/EV_BUSY : evaluator side
//   BUSY/DONE/ERROR : sequencer status
// master = the sequencer, slave = token source plus evaluator.
interface infix_sequencer_if #(
    parameter int DW = 8
);
    logic          TOK_VALID;
    logic          TOK_READY;
    logic [2:0]    TOK_KIND;
    logic [DW-1:0] TOK_DATA;
    logic [DW-1:0] EV_NUMBER;
    logic          EV_NUMBER_STB;
    logic [DW-1:0] EV_SIGN;
    logic          EV_SIGN_STB;
    logic          EV_BUSY;
    logic          BUSY;
    logic          DONE;
    logic          ERROR;

    modport master (
        input  TOK_VALID, TOK_KIND, TOK_DATA, EV_BUSY,
        output TOK_READY, EV_NUMBER, EV_NUMBER_STB, EV_SIGN, EV_SIGN_STB,
               BUSY, DONE, ERROR
    );

    modport slave (
        output TOK_VALID, TOK_KIND, TOK_DATA, EV_BUSY,
        input  TOK_READY, EV_NUMBER, EV_NUMBER_STB, EV_SIGN, EV_SIGN_STB,
               BUSY, DONE, ERROR
    );
endinterface

// File: rtl/infix_sequencer_op_lifo.sv
// Operator / left-parenthesis stack for the shunting-yard sequencer.
// Entry = {is_lpar, char}.
//   CLK, RST     : clock, synchronous active-high reset (empties the stack)
//   push_i       : write push_data_i on top (ignored when full)
//   pop_i        : discard top entry (ignored when empty)
//   top_o        : current top entry, valid when !empty_o
//   empty_o/full_o : occupancy flags
// The caller never asserts push_i and pop_i together.
module infix_sequencer_op_lifo #(
    parameter int OP_DEPTH = 8,
    parameter int EW       = 9
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          push_i,
    input  logic          pop_i,
    input  logic [EW-1:0] push_data_i,
    output logic [EW-1:0] top_o,
    output logic          empty_o,
    output logic          full_o
);
    localparam int AW = (OP_DEPTH > 1) ? $clog2(OP_DEPTH) : 1;
    localparam int CW = $clog2(OP_DEPTH + 1);

    logic [EW-1:0] mem_q [OP_DEPTH];
    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;
    logic [CW-1:0] top_idx;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CW'(OP_DEPTH));
    assign top_idx = count_q - CW'(1);
    assign top_o   = mem_q[top_idx[AW-1:0]];

    always_comb begin
        count_d = count_q;
        if (push_i && !full_o) begin
            count_d = count_q + CW'(1);
        end else if (pop_i && !empty_o) begin
            count_d = count_q - CW'(1);
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    // Storage needs no reset: only entries below count_q are ever read.
    always_ff @(posedge CLK) begin
        if (push_i && !full_o) begin
            mem_q[count_q[AW-1:0]] <= push_data_i;
        end
    end

endmodule

// File: rtl/infix_sequencer.sv
// Infix-to-postfix front end for the postfix evaluator (shunting-yard).
// Numbers are forwarded straight away; operators are parked in an internal
// LIFO and released by precedence, parentheses or the END token. Every
// emitted token is a one-cycle strobe on EV_NUMBER_STB or EV_SIGN_STB; the
// expression is closed by both strobes together.
//   CLK, RST : clock, synchronous active-high reset
//   bus      : token channel, evaluator interface and status (master side)
// Requires DW >= 8 (operators are 8-bit ASCII).
module infix_sequencer
    import infix_sequencer_pkg::*;
#(
    parameter int OP_DEPTH = 8,
    parameter int DW       = 8
) (
    input  logic                CLK,
    input  logic                RST,
    infix_sequencer_if.master   bus
);
    localparam logic [DW:0] LPAR_ENTRY = {1'b1, DW'(CH_LPAR)};

    state_e        state_q, state_d;
    logic          num_stb_q, num_stb_d;
    logic          sign_stb_q, sign_stb_d;
    logic [DW-1:0] ev_number_q, ev_number_d;
    logic [DW-1:0] ev_sign_q, ev_sign_d;
    logic          done_q, done_d;
    logic          error_q, error_d;
    logic [DW-1:0] tok_q, tok_d;

    logic          push, pop;
    logic [DW:0]   push_data;
    logic [DW:0]   top;
    logic          empty, full;

    logic          tok_ready;
    logic          fire;
    logic          op_valid;
    logic          top_is_op;
    logic          top_prec_ok;
    logic          can_issue;

    infix_sequencer_op_lifo #(
        .OP_DEPTH (OP_DEPTH),
        .EW       (DW + 1)
    ) u_lifo (
        .CLK         (CLK),
        .RST         (RST),
        .push_i      (push),
        .pop_i       (pop),
        .push_data_i (push_data),
        .top_o       (top),
        .empty_o     (empty),
        .full_o      (full)
    );

    assign tok_ready   = (state_q == ST_ACCEPT) && !error_q && !RST;
    assign fire        = bus.TOK_VALID && tok_ready;
    assign op_valid    = (prec(bus.TOK_DATA[7:0]) != 2'd0) && ((bus.TOK_DATA >> 8) == '0);
    assign top_is_op   = !empty && !top[DW];
    // Left-associative: equal precedence also pops.
    assign top_prec_ok = top_is_op && (prec(top[7:0]) >= prec(tok_q[7:0]));
    // A strobe in the current cycle blocks the next one, so the evaluator's
    // registered BUSY has time to appear before we look at it again.
    assign can_issue   = !bus.EV_BUSY && !num_stb_q && !sign_stb_q;

    // State and output registers
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= ST_ACCEPT;
            num_stb_q   <= 1'b0;
            sign_stb_q  <= 1'b0;
            ev_number_q <= '0;
            ev_sign_q   <= '0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            num_stb_q   <= num_stb_d;
            sign_stb_q  <= sign_stb_d;
            ev_number_q <= ev_number_d;
            ev_sign_q   <= ev_sign_d;
            done_q      <= done_d;
            error_q     <= error_d;
        end
    end

    always_ff @(posedge CLK) begin
        tok_q <= tok_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_ACCEPT: begin
                if (fire) begin
                    case (bus.TOK_KIND)
                        TOK_NUM:  state_d = ST_EMIT_NUM;
                        TOK_OP:   state_d = op_valid ? ST_POP_PREC : ST_ERR;
                        TOK_LPAR: state_d = full ? ST_ERR : ST_ACCEPT;
                        TOK_RPAR: state_d = ST_POP_PAREN;
                        TOK_END:  state_d = ST_FLUSH;
                        default:  state_d = ST_ERR;
                    endcase
                end
            end
            ST_EMIT_NUM:  if (can_issue) state_d = ST_ACCEPT;
            ST_POP_PREC:  if (!top_prec_ok) state_d = ST_PUSH_OP;
            ST_PUSH_OP:   state_d = full ? ST_ERR : ST_ACCEPT;
            ST_POP_PAREN: begin
                if (empty)        state_d = ST_ERR;
                else if (top[DW]) state_d = ST_ACCEPT;
            end
            ST_FLUSH: begin
                if (empty)        state_d = ST_FINISH;
                else if (top[DW]) state_d = ST_ERR;
            end
            ST_FINISH:    if (can_issue) state_d = ST_ACCEPT;
            ST_ERR:       state_d = ST_ERR;
            default:      state_d = ST_ERR;
        endcase
    end

    // Output / datapath logic
    always_comb begin
        num_stb_d   = 1'b0;
        sign_stb_d  = 1'b0;
        ev_number_d = ev_number_q;
        ev_sign_d   = ev_sign_q;
        done_d      = done_q;
        tok_d       = tok_q;
        push        = 1'b0;
        pop         = 1'b0;
        push_data   = {1'b0, tok_q};
        case (state_q)
            ST_ACCEPT: begin
                if (fire) begin
                    done_d = 1'b0;
                    tok_d  = bus.TOK_DATA;
                    if (bus.TOK_KIND == TOK_LPAR && !full) begin
                        push      = 1'b1;
                        push_data = LPAR_ENTRY;
                    end
                end
            end
            ST_EMIT_NUM: begin
                if (can_issue) begin
                    num_stb_d   = 1'b1;
                    ev_number_d = tok_q;
                end
            end
            ST_POP_PREC: begin
                if (top_prec_ok && can_issue) begin
                    sign_stb_d = 1'b1;
                    ev_sign_d  = top[DW-1:0];
                    pop        = 1'b1;
                end
            end
            ST_PUSH_OP: begin
                push = !full;
            end
            ST_POP_PAREN, ST_FLUSH: begin
                // The matching '(' is dropped without a strobe; in FLUSH a
                // '(' on top is an error and is left for the ERR state.
                if (state_q == ST_POP_PAREN && !empty && top[DW]) begin
                    pop = 1'b1;
                end else if (top_is_op && can_issue) begin
                    sign_stb_d = 1'b1;
                    ev_sign_d  = top[DW-1:0];
                    pop        = 1'b1;
                end
            end
            ST_FINISH: begin
                if (can_issue) begin
                    num_stb_d  = 1'b1;
                    sign_stb_d = 1'b1;
                    done_d     = 1'b1;
                end
            end
            default: ;
        endcase
        error_d = error_q || (state_d == ST_ERR);
    end

    assign bus.TOK_READY     = tok_ready;
    assign bus.EV_NUMBER     = ev_number_q;
    assign bus.EV_NUMBER_STB = num_stb_q;
    assign bus.EV_SIGN       = ev_sign_q;
    assign bus.EV_SIGN_STB   = sign_stb_q;
    assign bus.BUSY          = (state_q != ST_ACCEPT);
    assign bus.DONE          = done_q;
    assign bus.ERROR         = error_q;

endmodule
